// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low a..g patterns, index = hex digit value.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned p;
        int unsigned r;
        p = 1;
        r = 0;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex digit to active-low seven-segment lookup.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_c
);

    assign seg_c = HEX_SEG[digit];

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with double-buffered digits, leading-zero
// blanking, per-digit decimal points, PWM brightness and a frame strobe.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 1024,
    parameter int unsigned BRIGHT_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned VAL_W    = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W    = clog2(REFRESH_DIV);
    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam int unsigned PH_SHIFT = CNT_W - BRIGHT_W;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      pend_val;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [VAL_W-1:0]      disp_val;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic                  tick;
    logic                  last_idx;
    logic                  boundary;
    logic [BRIGHT_W-1:0]   phase;
    logic                  lit;
    logic                  show;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_run;
    logic [3:0]            sel_digit;
    logic                  sel_dp;
    logic                  sel_blank;
    logic [6:0]            dec_seg;

    assign tick     = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign last_idx = (idx == IDX_W'(NUM_DIGITS - 1));
    assign boundary = tick && last_idx;
    assign phase    = BRIGHT_W'(cnt >> PH_SHIFT);
    assign lit      = (phase <= brightness);

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            zero_run    = zero_run && (disp_val[4*i +: 4] == 4'h0);
            lz_blank[i] = blank_lz && zero_run;
        end
    end

    always_comb begin
        sel_digit = 4'h0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx == IDX_W'(i)) begin
                sel_digit = disp_val[4*i +: 4];
                sel_dp    = disp_dp[i];
                sel_blank = lz_blank[i];
            end
        end
    end

    assign show = enable && lit && !sel_blank;

    seg_hex_decoder u_dec (
        .digit (sel_digit),
        .seg_c (dec_seg)
    );

    // Slot prescaler and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                idx <= last_idx ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Pending buffer takes loads any time; display only changes between frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_val <= '0;
            pend_dp  <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
        end else begin
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end
            if (boundary) begin
                disp_val <= load ? value : pend_val;
                disp_dp  <= load ? dp_in : pend_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (show) begin
                an  <= ~(NUM_DIGITS'(1) << idx);
                seg <= dec_seg;
                dp  <= ~sel_dp;
            end else begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end
        end
    end

endmodule
